// File: rtl/assert_evt_pkg.sv
// ---------------------------------------------------------------------------
// assert_evt_pkg
// Shared definitions for the assertion event collector:
//   - default widths for the timestamp and the violation counter
//   - CNT_MAX, the saturation value of the default-width counter
//   - evt_rec_t, the layout of one queued event record (source, timestamp)
//   - lowest_set_idx, the priority function that picks the reported source
// ---------------------------------------------------------------------------
package assert_evt_pkg;

   localparam int EVT_TS_W  = 32;
   localparam int EVT_CNT_W = 16;

   localparam logic [EVT_CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [4:0]          src;
      logic [EVT_TS_W-1:0] ts;
   } evt_rec_t;

   // Index of the lowest set bit; 0 when nothing is set. Scanning from the
   // top down lets the lowest hit overwrite the others.
   function automatic logic [4:0] lowest_set_idx(input logic [31:0] v);
      logic [4:0] idx;
      idx = '0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) idx = i[4:0];
      end
      return idx;
   endfunction

endpackage

// File: rtl/assert_evt_fifo.sv
// ---------------------------------------------------------------------------
// assert_evt_fifo
// Synchronous FIFO for event records, with a flush input.
//   - A push into a full FIFO is accepted when a pop happens in the same cycle.
//   - On flush, any pop in the same cycle completes, then the FIFO is emptied.
//     A push in the same cycle becomes the only entry.
//   - o_data is 0 while empty and holds the head entry otherwise.
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   i_push          write i_data (dropped if full without a pop)
//   i_pop_req       reader ready; pops when the FIFO is non-empty
//   i_flush         discard all stored entries
//   i_data          record to write
//   o_valid         FIFO non-empty
//   o_full          FIFO holds DEPTH entries
//   o_data          head record
// ---------------------------------------------------------------------------
module assert_evt_fifo #(
   parameter int DW    = 37,
   parameter int DEPTH = 4
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          i_push,
   input  logic          i_pop_req,
   input  logic          i_flush,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   output logic          o_full,
   output logic [DW-1:0] o_data
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_count;

   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push_ok;
   logic [AW-1:0] w_wr_addr;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == (AW+1)'(DEPTH));
   assign w_pop     = ~w_empty & i_pop_req;
   // A flush frees every slot, so the incoming record always fits then.
   assign w_push_ok = i_push & (i_flush | ~w_full | w_pop);
   assign w_wr_addr = i_flush ? '0 : r_wr;

   always_ff @(posedge clock) begin
      if (w_push_ok) r_mem[w_wr_addr] <= i_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_rd    <= '0;
         r_wr    <= w_push_ok ? AW'(1) : '0;
         r_count <= w_push_ok ? (AW+1)'(1) : '0;
      end else begin
         if (w_push_ok) r_wr <= r_wr + 1'b1;
         if (w_pop)     r_rd <= r_rd + 1'b1;
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_valid = ~w_empty;
   assign o_full  = w_full;
   assign o_data  = w_empty ? '0 : r_mem[r_rd];

endmodule

// File: rtl/assert_event_collector.sv
// ---------------------------------------------------------------------------
// assert_event_collector
// Receiving end of the per-checker assertion monitors. Latches one-cycle
// violation pulses into sticky status, counts violating cycles, queues a
// (source, timestamp) record per violating cycle for a debug reader and
// raises irq plus a halt request for fatal-masked sources.
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   fire            per-checker violation pulses
//   src_en          per-source enable (disabled sources are ignored)
//   fatal_mask      sources whose violation requests a halt
//   clr             clear status/count/flags and flush the record FIFO
//   sticky          per-source sticky violation bits
//   viol_cnt        saturating count of cycles with an enabled violation
//   overflow        sticky: a record was dropped on a full FIFO
//   multi           sticky: two or more sources hit in one cycle
//   irq             |sticky | overflow
//   halt_req        sticky: a fatal-masked source hit
//   evt_valid/evt_ready/evt_src/evt_ts  record read port (valid/ready)
// ---------------------------------------------------------------------------
module assert_event_collector
   import assert_evt_pkg::*;
#(
   parameter int N_SRC      = 8,
   parameter int CNT_W      = EVT_CNT_W,
   parameter int TS_W       = EVT_TS_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [N_SRC-1:0] fire,
   input  logic [N_SRC-1:0] src_en,
   input  logic [N_SRC-1:0] fatal_mask,
   input  logic             clr,
   output logic [N_SRC-1:0] sticky,
   output logic [CNT_W-1:0] viol_cnt,
   output logic             overflow,
   output logic             multi,
   output logic             irq,
   output logic             halt_req,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [4:0]       evt_src,
   output logic [TS_W-1:0]  evt_ts
);

   localparam int REC_W = 5 + TS_W;

   logic [TS_W-1:0]  r_ts;
   logic [N_SRC-1:0] r_sticky;
   logic [CNT_W-1:0] r_cnt;
   logic             r_overflow;
   logic             r_multi;
   logic             r_halt;

   logic [N_SRC-1:0] w_act;
   logic             w_any;
   logic             w_multi_hit;
   logic             w_fatal_hit;
   logic [4:0]       w_src;
   logic             w_full;
   logic             w_pop;
   logic             w_drop;
   logic [REC_W-1:0] w_rd_data;

   assign w_act       = fire & src_en;
   assign w_any       = |w_act;
   // Clearing the lowest set bit leaves something only if >= 2 bits were set.
   assign w_multi_hit = |(w_act & (w_act - 1'b1));
   assign w_fatal_hit = |(w_act & fatal_mask);
   assign w_src       = lowest_set_idx(32'(w_act));
   assign w_pop       = evt_valid & evt_ready;
   // A clr flushes the FIFO first, so a record arriving with clr never drops.
   assign w_drop      = w_any & w_full & ~w_pop & ~clr;

   // Free-running timestamp, deliberately untouched by clr.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_ts <= '0;
      else          r_ts <= r_ts + 1'b1;
   end

   // Status: clr wipes the old state, and the current cycle's event is then
   // applied on top, so a clr coinciding with a hit leaves just that hit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sticky   <= '0;
         r_cnt      <= '0;
         r_overflow <= 1'b0;
         r_multi    <= 1'b0;
         r_halt     <= 1'b0;
      end else if (clr) begin
         r_sticky   <= w_act;
         r_cnt      <= w_any ? CNT_W'(1) : '0;
         r_overflow <= 1'b0;
         r_multi    <= w_multi_hit;
         r_halt     <= w_fatal_hit;
      end else begin
         r_sticky   <= r_sticky | w_act;
         if (w_any && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
         r_overflow <= r_overflow | w_drop;
         r_multi    <= r_multi | w_multi_hit;
         r_halt     <= r_halt | w_fatal_hit;
      end
   end

   assert_evt_fifo #(
      .DW    (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .i_push    (w_any),
      .i_pop_req (evt_ready),
      .i_flush   (clr),
      .i_data    ({w_src, r_ts}),
      .o_valid   (evt_valid),
      .o_full    (w_full),
      .o_data    (w_rd_data)
   );

   assign sticky   = r_sticky;
   assign viol_cnt = r_cnt;
   assign overflow = r_overflow;
   assign multi    = r_multi;
   assign halt_req = r_halt;
   assign irq      = (|r_sticky) | r_overflow;
   assign evt_src  = w_rd_data[TS_W +: 5];
   assign evt_ts   = w_rd_data[TS_W-1:0];

endmodule

// File: tb/tb_assert_event_collector.sv
module tb_assert_event_collector;
   import assert_evt_pkg::*;

   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  fire = '0;
   logic [7:0]  srcEn = '0;
   logic [7:0]  fatalMask = '0;
   logic        clr = 1'b0;
   logic        evtReady = 1'b0;

   logic [7:0]  sticky;
   logic [15:0] violCnt;
   logic        overflow, multi, irq, haltReq, evtValid;
   logic [4:0]  evtSrc;
   logic [31:0] evtTs;

   logic [7:0]  sticky4;
   logic [3:0]  violCnt4;
   logic        overflow4, multi4, irq4, haltReq4, evtValid4;
   logic [4:0]  evtSrc4;
   logic [31:0] evtTs4;

   // Behavioural model state
   logic [7:0]  mSticky;
   int          mCnt16, mCnt4;
   logic        mOvf, mMulti, mHalt;
   logic [31:0] mTs;
   evt_rec_t    mQ[$];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   assert_event_collector dut (
      .clock(clock), .reset_n(reset_n), .fire(fire), .src_en(srcEn),
      .fatal_mask(fatalMask), .clr(clr), .sticky(sticky), .viol_cnt(violCnt),
      .overflow(overflow), .multi(multi), .irq(irq), .halt_req(haltReq),
      .evt_valid(evtValid), .evt_ready(evtReady), .evt_src(evtSrc), .evt_ts(evtTs)
   );

   assert_event_collector #(.CNT_W(4)) dut4 (
      .clock(clock), .reset_n(reset_n), .fire(fire), .src_en(srcEn),
      .fatal_mask(fatalMask), .clr(clr), .sticky(sticky4), .viol_cnt(violCnt4),
      .overflow(overflow4), .multi(multi4), .irq(irq4), .halt_req(haltReq4),
      .evt_valid(evtValid4), .evt_ready(evtReady), .evt_src(evtSrc4), .evt_ts(evtTs4)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      mSticky = '0; mCnt16 = 0; mCnt4 = 0;
      mOvf = 1'b0; mMulti = 1'b0; mHalt = 1'b0;
      mTs = '0;
      mQ.delete();
   endtask

   // One clock edge of the specified behaviour, using the current inputs.
   task automatic modelStep();
      logic [7:0] act;
      evt_rec_t   rec;
      int         lo;
      act = fire & srcEn;
      if (evtReady && mQ.size() > 0) mQ.delete(0);
      if (clr) begin
         mSticky = '0; mCnt16 = 0; mCnt4 = 0;
         mOvf = 1'b0; mMulti = 1'b0; mHalt = 1'b0;
         mQ.delete();
      end
      if (act != 0) begin
         mSticky |= act;
         if (mCnt16 < int'(CNT_MAX)) mCnt16++;
         if (mCnt4 < 15) mCnt4++;
         if ($countones(act) >= 2) mMulti = 1'b1;
         if ((act & fatalMask) != 0) mHalt = 1'b1;
         lo = 0;
         for (int i = 7; i >= 0; i--) if (act[i]) lo = i;
         rec.src = 5'(lo);
         rec.ts  = mTs;
         if (mQ.size() < DEPTH) mQ.push_back(rec);
         else                   mOvf = 1'b1;
      end
      mTs++;
   endtask

   task automatic checkOutput();
      logic [4:0]  eSrc;
      logic [31:0] eTs;
      logic        eIrq;
      eSrc = (mQ.size() > 0) ? mQ[0].src : 5'd0;
      eTs  = (mQ.size() > 0) ? mQ[0].ts  : 32'd0;
      eIrq = (|mSticky) | mOvf;
      check("sticky",    64'(sticky),    64'(mSticky));
      check("viol_cnt",  64'(violCnt),   64'(mCnt16));
      check("overflow",  64'(overflow),  64'(mOvf));
      check("multi",     64'(multi),     64'(mMulti));
      check("halt_req",  64'(haltReq),   64'(mHalt));
      check("irq",       64'(irq),       64'(eIrq));
      check("evt_valid", 64'(evtValid),  64'(mQ.size() > 0));
      check("evt_src",   64'(evtSrc),    64'(eSrc));
      check("evt_ts",    64'(evtTs),     64'(eTs));
      check("cnt4",      64'(violCnt4),  64'(mCnt4));
      check("sticky4",   64'(sticky4),   64'(mSticky));
      check("ovf4",      64'(overflow4), 64'(mOvf));
      check("multi4",    64'(multi4),    64'(mMulti));
      check("halt4",     64'(haltReq4),  64'(mHalt));
      check("irq4",      64'(irq4),      64'(eIrq));
      check("valid4",    64'(evtValid4), 64'(mQ.size() > 0));
      check("src4",      64'(evtSrc4),   64'(eSrc));
      check("ts4",       64'(evtTs4),    64'(eTs));
   endtask

   // Called at a negedge: drive inputs, step through one posedge, check at next negedge.
   task automatic applyStimulus(input logic [7:0] f, input logic [7:0] en,
                                input logic [7:0] fm, input logic c, input logic r);
      fire = f; srcEn = en; fatalMask = fm; clr = c; evtReady = r;
      @(posedge clock);
      modelStep();
      @(negedge clock);
      checkOutput();
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_sticky"}, 64'(sticky),   64'h0);
      check({tag, "_cnt"},    64'(violCnt),  64'h0);
      check({tag, "_ovf"},    64'(overflow), 64'h0);
      check({tag, "_multi"},  64'(multi),    64'h0);
      check({tag, "_irq"},    64'(irq),      64'h0);
      check({tag, "_halt"},   64'(haltReq),  64'h0);
      check({tag, "_valid"},  64'(evtValid), 64'h0);
      check({tag, "_src"},    64'(evtSrc),   64'h0);
      check({tag, "_ts"},     64'(evtTs),    64'h0);
      check({tag, "_cnt4"},   64'(violCnt4), 64'h0);
   endtask

   initial begin
      int exp4[4];
      modelReset();
      repeat (2) @(negedge clock);
      checkAllZero("reset");
      reset_n = 1'b1;

      // 1: single fire at timestamp 10
      repeat (10) applyStimulus(8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
      applyStimulus(8'h04, 8'hFF, 8'h00, 1'b0, 1'b0);
      check("t1_sticky", 64'(sticky),   64'h04);
      check("t1_cnt",    64'(violCnt),  64'd1);
      check("t1_valid",  64'(evtValid), 64'd1);
      check("t1_src",    64'(evtSrc),   64'd2);
      check("t1_ts",     64'(evtTs),    64'd10);
      check("t1_irq",    64'(irq),      64'd1);
      applyStimulus(8'h00, 8'hFF, 8'h00, 1'b0, 1'b1);
      check("t1_drained", 64'(evtValid), 64'd0);

      // 2: two sources in one cycle, one of them fatal
      applyStimulus(8'h00, 8'hFF, 8'h80, 1'b1, 1'b0);
      applyStimulus(8'h90, 8'hFF, 8'h80, 1'b0, 1'b0);
      check("t2_src",    64'(evtSrc),  64'd4);
      check("t2_multi",  64'(multi),   64'd1);
      check("t2_halt",   64'(haltReq), 64'd1);
      check("t2_sticky", 64'(sticky),  64'h90);
      applyStimulus(8'h00, 8'hFF, 8'h80, 1'b0, 1'b1);
      check("t2_one_rec", 64'(evtValid), 64'd0);

      // 3: five fires without reading, then drain in order
      applyStimulus(8'h00, 8'hFF, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(8'(1 << i), 8'hFF, 8'h00, 1'b0, 1'b0);
         if (i == 3) check("t3_ovf_before", 64'(overflow), 64'd0);
      end
      check("t3_ovf_after", 64'(overflow), 64'd1);
      for (int i = 0; i < 4; i++) begin
         check("t3_order", 64'(evtSrc), 64'(i));
         applyStimulus(8'h00, 8'hFF, 8'h00, 1'b0, 1'b1);
      end
      check("t3_empty", 64'(evtValid), 64'd0);

      // 4: full FIFO, push and pop together
      applyStimulus(8'h00, 8'hFF, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(8'(1 << i), 8'hFF, 8'h00, 1'b0, 1'b0);
      applyStimulus(8'h20, 8'hFF, 8'h00, 1'b0, 1'b1);
      check("t4_ovf", 64'(overflow), 64'd0);
      exp4 = '{1, 2, 3, 5};
      for (int k = 0; k < 4; k++) begin
         check("t4_order", 64'(evtSrc), 64'(exp4[k]));
         applyStimulus(8'h00, 8'hFF, 8'h00, 1'b0, 1'b1);
      end
      check("t4_empty", 64'(evtValid), 64'd0);

      // 5: clr together with a new fire after prior activity
      repeat (6) applyStimulus(8'hC0, 8'hFF, 8'h80, 1'b0, 1'b0);
      check("t5_pre_halt", 64'(haltReq),  64'd1);
      check("t5_pre_ovf",  64'(overflow), 64'd1);
      applyStimulus(8'h01, 8'hFF, 8'h80, 1'b1, 1'b0);
      check("t5_sticky", 64'(sticky),   64'h01);
      check("t5_cnt",    64'(violCnt),  64'd1);
      check("t5_ovf",    64'(overflow), 64'd0);
      check("t5_halt",   64'(haltReq),  64'd0);
      check("t5_valid",  64'(evtValid), 64'd1);
      applyStimulus(8'h00, 8'hFF, 8'h80, 1'b0, 1'b1);
      check("t5_one_rec", 64'(evtValid), 64'd0);

      // 6: disabled sources are ignored; narrow counter saturates
      applyStimulus(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
      check("t6_dis_sticky", 64'(sticky),  64'h01);
      check("t6_dis_cnt",    64'(violCnt), 64'd1);
      check("t6_dis_halt",   64'(haltReq), 64'd0);
      applyStimulus(8'h00, 8'hFF, 8'h00, 1'b1, 1'b0);
      repeat (20) applyStimulus(8'($urandom_range(1, 255)), 8'hFF, 8'h00, 1'b0, 1'($urandom_range(0, 1)));
      check("t6_cnt4", 64'(violCnt4), 64'd15);
      check("t6_cnt16", 64'(violCnt), 64'd20);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [7:0] f, en;
         f  = ($urandom_range(0, 2) == 0) ? 8'h00 : (8'($urandom) & 8'($urandom));
         en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         applyStimulus(f, en, 8'($urandom) & 8'($urandom) & 8'($urandom),
                       1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 2) != 0));
      end

      // Reset in the middle of a burst
      repeat (3) applyStimulus(8'h0F, 8'hFF, 8'h08, 1'b0, 1'b0);
      #2 reset_n = 1'b0;
      fire = '0; clr = 1'b0; evtReady = 1'b0;
      #1 checkAllZero("midrst");
      modelReset();
      @(negedge clock);
      reset_n = 1'b1;
      applyStimulus(8'h02, 8'hFF, 8'h00, 1'b0, 1'b0);
      check("post_rst_ts",  64'(evtTs),  64'd0);
      check("post_rst_src", 64'(evtSrc), 64'd1);
      repeat (30) applyStimulus(8'($urandom) & 8'($urandom), 8'hFF, 8'($urandom),
                                1'b0, 1'($urandom_range(0, 1)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
